qrr_arb: RTL and testbench

- Round-robin arbiter that shares one two-level-queue datapath (such as the take/slice blocks) between NUM_IN requesters.
- Each beat carries {eot[1:0], data}.
- A grant is held for a whole outer transaction, from the first beat through the beat with eot == 2'b11.
- The output is tagged with the source index so downstream logic can route results back.
- Sits in front of shared queue-processing stages in the cookbook library.

---
 rtl/qrr_arb_pkg.sv | 17 +
 rtl/rr_prio_enc.sv | 29 ++
 rtl/qrr_arb.sv | 89 ++++++++
 tb/tb_qrr_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qrr_arb_pkg.sv
// Shared types and constants for the transaction-locked round-robin arbiter.
// The beat layout is {eot[1:0], payload}; the payload width is set by each module.
package qrr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [1:0] EOT_LAST = 2'b11;

    // Only the outer end marker closes a transaction; 2'b01 and 2'b10 keep it open.
    function automatic logic is_last(input logic [1:0] eot);
        return eot == EOT_LAST;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: picks the first set request at or after ptr, wrapping at N.
// Purely combinational so it can sit in any arbiter's grant path.
module rr_prio_enc #(
    parameter int N = 2,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any_req
);

    // Walk from the farthest offset down so the nearest request is the one that sticks.
    always_comb begin
        int idx;
        gnt_idx = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx[SEL_W-1:0]]) begin
                gnt_idx = idx[SEL_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qrr_arb.sv
// Round-robin arbiter that holds its grant for a whole outer transaction and tags each
// forwarded beat with the source index; forwarding is zero-latency.
module qrr_arb
    import qrr_arb_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int DIN_W  = 16,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IN-1:0]             din_valid,
    output logic [NUM_IN-1:0]             din_ready,
    input  logic [NUM_IN-1:0][DIN_W-1:0]  din_data,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [SEL_W+DIN_W-1:0]        dout_data
);

    typedef struct packed {
        logic [1:0]       eot;
        logic [DIN_W-3:0] payload;
    } qbeat_t;

    state_t           state;
    logic [SEL_W-1:0] lock_sel;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] grant;
    logic             any_req;
    logic             handshake;
    logic             last;
    qbeat_t           beat;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] s);
        if (int'(s) == NUM_IN - 1) return '0;
        return s + 1'b1;
    endfunction

    rr_prio_enc #(.N(NUM_IN)) u_enc (
        .req     (din_valid),
        .ptr     (rr_ptr),
        .gnt_idx (scan_idx),
        .any_req (any_req)
    );

    assign grant      = (state == LOCKED) ? lock_sel : scan_idx;
    assign beat       = qbeat_t'(din_data[grant]);
    assign dout_valid = !rst && ((state == LOCKED) ? din_valid[lock_sel] : any_req);
    assign dout_data  = {grant, beat};
    assign handshake  = dout_valid && dout_ready;
    assign last       = is_last(beat.eot);

    always_comb begin
        din_ready = '0;
        if (!rst) din_ready[grant] = dout_ready;
    end

    // Any presented beat that does not finish the transaction locks the grant, which also
    // keeps a stalled beat from being re-arbitrated away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lock_sel <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dout_valid) begin
                        if (handshake && last) begin
                            rr_ptr <= wrap_inc(grant);
                        end else begin
                            state    <= LOCKED;
                            lock_sel <= grant;
                        end
                    end
                end
                LOCKED: begin
                    if (handshake && last) begin
                        state  <= IDLE;
                        rr_ptr <= wrap_inc(lock_sel);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qrr_arb.sv
// Bench for qrr_arb with three inputs: queue-fed sources, a per-cycle reference model
// of the grant rules, and literal expected handshake sequences per scenario.
module tb_qrr_arb;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int OW = 18;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N-1:0]          din_valid = '0;
    logic [N-1:0]          din_ready;
    logic [N-1:0][DW-1:0]  din_data = '0;
    logic                  dout_valid;
    logic                  dout_ready = 1'b0;
    logic [OW-1:0]         dout_data;

    qrr_arb #(.NUM_IN(N), .DIN_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source side: each input presents the head of its queue once its start cycle arrives.
    logic [DW-1:0] srcq [N][$];
    int            start_cyc [N];
    int            cyc = 0;
    int            rdy_start = 0;
    bit            rdy_toggle = 0;
    int            rst_cyc = -1;
    bit            fire [N];

    // Handshake log and the literal expectation it is compared against.
    logic [OW-1:0] log_q [$];
    int            log_cyc [$];
    logic [OW-1:0] exp_q [$];

    function automatic logic [DW-1:0] bt(input logic [1:0] e, input int p);
        return {e, p[13:0]};
    endfunction

    function automatic logic [OW-1:0] mk(input int s, input logic [1:0] e, input int p);
        return {s[1:0], e, p[13:0]};
    endfunction

    // Reference model: arbitration state expressed as plain integers.
    int m_locked = 0;
    int m_owner  = 0;
    int m_ptr    = 0;

    function automatic int exp_grant();
        int idx;
        if (m_locked != 0) return m_owner;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (din_valid[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int  g;
        bit  v, hs, lst;
        if (rst) begin
            m_locked = 0;
            m_owner  = 0;
            m_ptr    = 0;
        end else begin
            g = exp_grant();
            v = (g >= 0) && din_valid[g[1:0]];
            hs = v && dout_ready;
            lst = v && (din_data[g[1:0]][DW-1:DW-2] == 2'b11);
            if (m_locked == 0) begin
                if (v) begin
                    if (hs && lst) m_ptr = (g + 1) % N;
                    else begin
                        m_locked = 1;
                        m_owner  = g;
                    end
                end
            end else if (hs && lst) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % N;
            end
        end
    end

    // Per-cycle comparison against the model, plus the handshake log.
    always @(negedge clk) begin
        int g;
        bit v;
        if (rst) begin
            chk("rst_dout_valid", 32'(dout_valid), 32'd0);
            chk("rst_din_ready", 32'(din_ready), 32'd0);
        end else begin
            g = exp_grant();
            if (g < 0) begin
                chk("idle_dout_valid", 32'(dout_valid), 32'd0);
            end else begin
                v = din_valid[g[1:0]];
                chk("dout_valid", 32'(dout_valid), 32'(v));
                if (v) chk("dout_data", 32'(dout_data), 32'({g[1:0], din_data[g[1:0]]}));
                chk("din_ready", 32'(din_ready), dout_ready ? (32'd1 << g) : 32'd0);
            end
            if (dout_valid && dout_ready) begin
                log_q.push_back(dout_data);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && cyc >= start_cyc[i]) begin
                din_valid[i] = 1'b1;
                din_data[i]  = srcq[i][0];
            end else begin
                din_valid[i] = 1'b0;
                din_data[i]  = '0;
            end
        end
        dout_ready = (cyc >= rdy_start) && (!rdy_toggle || ((cyc - rdy_start) % 2 == 0));
        rst = (cyc == rst_cyc);
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) fire[i] = din_valid[i] && din_ready[i];
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (fire[i]) void'(srcq[i].pop_front());
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic setup(input int rs, input bit tog, input int rc);
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            start_cyc[i] = 0;
        end
        rdy_start  = rs;
        rdy_toggle = tog;
        rst_cyc    = rc;
        exp_q.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        din_valid = '0;
        dout_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        log_q.delete();
        log_cyc.delete();
        cyc = 0;
        drive();
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk({name, "_beat"}, 32'(log_q[i]), 32'(exp_q[i]));
        log_q.delete();
        log_cyc.delete();
    endtask

    initial begin
        // Single source, three-beat transaction with an inner-only end in the middle.
        setup(0, 0, -1);
        srcq[0] = '{bt(2'b00, 'h001), bt(2'b01, 'h002), bt(2'b11, 'h003)};
        reset_dut();
        run(4);
        chk("t1_consecutive", 32'(log_cyc.size() == 3 && log_cyc[2] - log_cyc[0] == 2), 32'd1);
        exp_q = '{mk(0, 2'b00, 'h001), mk(0, 2'b01, 'h002), mk(0, 2'b11, 'h003)};
        check_log("t1");

        // Pointer now sits at 1, so input 1 wins a tie with input 0.
        srcq[0] = '{bt(2'b11, 'h010)};
        srcq[1] = '{bt(2'b11, 'h110)};
        drive();
        run(3);
        exp_q = '{mk(1, 2'b11, 'h110), mk(0, 2'b11, 'h010)};
        check_log("t1_ptr");

        // Two simultaneous two-beat transactions from reset.
        setup(0, 0, -1);
        srcq[0] = '{bt(2'b00, 'h040), bt(2'b11, 'h041)};
        srcq[1] = '{bt(2'b00, 'h140), bt(2'b11, 'h141)};
        reset_dut();
        run(6);
        exp_q = '{mk(0, 2'b00, 'h040), mk(0, 2'b11, 'h041),
                  mk(1, 2'b00, 'h140), mk(1, 2'b11, 'h141)};
        check_log("t2");

        // Locked on input 1 while input 0 requests and ready toggles.
        setup(0, 1, -1);
        srcq[1] = '{bt(2'b00, 'h130), bt(2'b00, 'h131), bt(2'b11, 'h132)};
        srcq[0] = '{bt(2'b11, 'h030)};
        start_cyc[0] = 1;
        reset_dut();
        run(9);
        exp_q = '{mk(1, 2'b00, 'h130), mk(1, 2'b00, 'h131),
                  mk(1, 2'b11, 'h132), mk(0, 2'b11, 'h030)};
        check_log("t3");

        // Stalled first beat on input 1 must not be stolen by input 0.
        setup(3, 0, -1);
        srcq[1] = '{bt(2'b00, 'h120), bt(2'b11, 'h121)};
        srcq[0] = '{bt(2'b11, 'h020)};
        start_cyc[0] = 1;
        reset_dut();
        run(8);
        exp_q = '{mk(1, 2'b00, 'h120), mk(1, 2'b11, 'h121), mk(0, 2'b11, 'h020)};
        check_log("t4");

        // Single-beat transactions from all inputs rotate 0,1,2 and wrap at 3.
        setup(0, 0, -1);
        for (int i = 0; i < N; i++)
            srcq[i] = '{bt(2'b11, i * 16), bt(2'b11, i * 16 + 1)};
        reset_dut();
        run(8);
        exp_q = '{mk(0, 2'b11, 'h00), mk(1, 2'b11, 'h10), mk(2, 2'b11, 'h20),
                  mk(0, 2'b11, 'h01), mk(1, 2'b11, 'h11), mk(2, 2'b11, 'h21)};
        check_log("t5");

        // Reset while locked on input 1: lock dropped, input 0 wins afterwards.
        setup(0, 0, 2);
        srcq[1] = '{bt(2'b00, 'h150), bt(2'b00, 'h151), bt(2'b00, 'h152), bt(2'b11, 'h153)};
        srcq[0] = '{bt(2'b11, 'h050)};
        start_cyc[0] = 2;
        reset_dut();
        run(9);
        exp_q = '{mk(1, 2'b00, 'h150), mk(1, 2'b00, 'h151), mk(0, 2'b11, 'h050),
                  mk(1, 2'b00, 'h152), mk(1, 2'b11, 'h153)};
        check_log("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
